// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction fetch stage with a small prefetch FIFO.
// Owns the fetch PC, issues word reads over a req/ack handshake, buffers
// returned words with their PCs and presents them to decode via valid/ready.
// A redirect flushes the buffer and discards any read still in flight.
// Optional feature: define FETCH_STALL_CNT_EN to add the stall_cycles counter.
module fetch_prefetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     instr_valid,
  output logic [DATA_W-1:0]        instr_out,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    REQ  = 2'd1,  // request outstanding, result will be kept
    DROP = 2'd2   // request outstanding for a stale address, result discarded
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] fetch_pc, pc_next, addr_next;
  logic [CNT_W-1:0]  count_next;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  entry_t            fifo_mem [DEPTH];
  entry_t            head;
  logic              xfer, push, pop, space;

  // Handshake events; a redirect overrides both push and pop on its edge.
  assign xfer  = mem_req & mem_ack;
  assign push  = xfer & (state == REQ) & ~redirect;
  assign pop   = instr_valid & instr_ready & ~redirect;
  assign space = count_next < FULL;

  // Occupancy and fetch PC after this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_next = fifo_count;
    pc_next    = fetch_pc;
    if (redirect) begin
      count_next = '0;
      pc_next    = redirect_pc;
    end else begin
      if (push && !pop) count_next = fifo_count + CNT_W'(1);
      else if (pop && !push) count_next = fifo_count - CNT_W'(1);
      if (push) pc_next = fetch_pc + ADDR_W'(1);
    end
  end

  // Next-state logic; mem_addr only moves when a new request is issued.
  always_comb begin
    state_next = state;
    addr_next  = mem_addr;
    case (state)
      IDLE: begin
        if (space) begin
          state_next = REQ;
          addr_next  = pc_next;
        end
      end
      REQ: begin
        if (xfer) begin
          state_next = space ? REQ : IDLE;
          addr_next  = pc_next;
        end else if (redirect) begin
          // Handshake is never withdrawn: keep the stale address until acked.
          state_next = DROP;
        end
      end
      DROP: begin
        if (xfer) begin
          state_next = space ? REQ : IDLE;
          addr_next  = pc_next;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, registered request/address and fetch PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state    <= state_next;
      mem_req  <= (state_next != IDLE);
      mem_addr <= addr_next;
      fetch_pc <= pc_next;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; fifo_count gates every read,
    // so stale contents are never observable.
    if (push) fifo_mem[wr_ptr] <= '{pc: fetch_pc, data: mem_rdata};
  end

  // FIFO pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_next;
    end
  end

  assign head        = fifo_mem[rd_ptr];
  assign instr_valid = (fifo_count != '0);
  assign instr_out   = instr_valid ? head.data : '0;
  assign instr_pc    = instr_valid ? head.pc   : '0;

`ifdef FETCH_STALL_CNT_EN
  // Count cycles where decode is ready but nothing is available; saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (instr_ready && !instr_valid && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Testbench for fetch_prefetch_unit: table-driven streaming/backpressure
// vectors plus hand-written redirect, wrap and reset sequences. Delivered
// instructions are compared against a queue of expected PCs.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [2:0]  fifo_count;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  fetch_prefetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fifo_count  (fifo_count)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: each word encodes its own address.
  function automatic logic [31:0] word_at(input logic [15:0] a);
    return {~a, a};
  endfunction
  assign mem_rdata = word_at(mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    tick();
    check("rst mem_req", mem_req, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst instr_valid", instr_valid, 0);
    check("rst instr_out", instr_out, 0);
    check("rst instr_pc", instr_pc, 0);
    check("rst fifo_count", fifo_count, 0);
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic drained(input string name);
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard: every accepted head must match the next expected PC/word.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected pop: got pc %0h expected none", instr_pc);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("pop pc", instr_pc, e);
        check("pop data", instr_out, word_at(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[16];

  initial begin
    //            ack   rdy   req   addr    valid pc      cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 16'd0, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'd1, 1'b1, 16'd0, 3'd1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'd2, 1'b1, 16'd1, 3'd1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'd3, 1'b1, 16'd2, 3'd1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 16'd3, 3'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'd5, 1'b1, 16'd3, 3'd2};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'd6, 1'b1, 16'd3, 3'd3};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'd7, 1'b1, 16'd3, 3'd4};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'd7, 1'b1, 16'd3, 3'd4};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'd7, 1'b1, 16'd4, 3'd3};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 16'd8, 1'b1, 16'd5, 3'd3};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 16'd8, 1'b1, 16'd6, 3'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 16'd8, 1'b1, 16'd6, 3'd2};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 16'd8, 1'b1, 16'd7, 3'd1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 16'd8, 1'b0, 16'd0, 3'd0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 16'd9, 1'b1, 16'd8, 3'd1};

    // Streaming, fill to full, drain and resume.
    do_reset();
    for (int p = 0; p <= 8; p++) exp_q.push_back(16'(p));
    for (int i = 0; i < 16; i++) begin
      mem_ack = vecs[i].ack;
      instr_ready = vecs[i].rdy;
      tick();
      check($sformatf("v%0d mem_req", i), mem_req, vecs[i].req);
      check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
      check($sformatf("v%0d instr_valid", i), instr_valid, vecs[i].valid);
      check($sformatf("v%0d fifo_count", i), fifo_count, vecs[i].cnt);
      if (vecs[i].valid) check($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].pc);
    end
    mem_ack = 1'b0;
    tick();
    drained("stream drained");

    // Stalled read at addr 5, redirect: stale read completes and is dropped.
    do_reset();
    mem_ack = 1'b1; instr_ready = 1'b1;
    for (int p = 0; p <= 4; p++) exp_q.push_back(16'(p));
    repeat (6) tick();
    check("drop pre addr", mem_addr, 16'd5);
    check("drop pre pc", instr_pc, 16'd4);
    mem_ack = 1'b0;
    repeat (3) tick();
    check("drop stall addr", mem_addr, 16'd5);
    check("drop stall count", fifo_count, 0);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    check("drop hold req", mem_req, 1);
    check("drop hold addr", mem_addr, 16'd5);
    check("drop hold count", fifo_count, 0);
    tick();
    check("drop hold2 addr", mem_addr, 16'd5);
    mem_ack = 1'b1;
    tick();
    check("drop ack addr", mem_addr, 16'h0040);
    check("drop ack valid", instr_valid, 0);
    check("drop ack count", fifo_count, 0);
    exp_q.push_back(16'h0040);
    tick();
    check("post drop pc", instr_pc, 16'h0040);
    check("post drop addr", mem_addr, 16'h0041);
    mem_ack = 1'b0;
    tick();
    check("post drop count", fifo_count, 0);
    drained("drop drained");

    // Redirect on the same edge as transfer and pop with 2 entries buffered.
    do_reset();
    mem_ack = 1'b1;
    repeat (3) tick();
    check("same-edge pre count", fifo_count, 2);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    check("same-edge count", fifo_count, 0);
    check("same-edge valid", instr_valid, 0);
    check("same-edge req", mem_req, 1);
    check("same-edge addr", mem_addr, 16'h0100);
    exp_q.push_back(16'h0100);
    tick();
    check("redir first valid", instr_valid, 1);
    check("redir first pc", instr_pc, 16'h0100);
    check("redir next addr", mem_addr, 16'h0101);
    mem_ack = 1'b0;
    tick();
    check("redir drain count", fifo_count, 0);

    // Address wrap FFFE, FFFF, 0000, 0001.
    mem_ack = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    check("wrap addr0", mem_addr, 16'hFFFE);
    check("wrap count0", fifo_count, 0);
    exp_q.push_back(16'hFFFE); exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000);
    tick();
    check("wrap addr1", mem_addr, 16'hFFFF);
    check("wrap pc1", instr_pc, 16'hFFFE);
    tick();
    check("wrap addr2", mem_addr, 16'h0000);
    check("wrap pc2", instr_pc, 16'hFFFF);
    tick();
    check("wrap addr3", mem_addr, 16'h0001);
    check("wrap pc3", instr_pc, 16'h0000);

    // Asynchronous reset while a read is in flight.
    #3;
    instr_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("async rst req", mem_req, 0);
    check("async rst addr", mem_addr, 0);
    check("async rst count", fifo_count, 0);
    check("async rst valid", instr_valid, 0);
    exp_q.delete();
    tick();
    check("rst ack ignored req", mem_req, 0);
    check("rst ack ignored count", fifo_count, 0);
    mem_ack = 1'b0;
    reset = 1'b1;
    tick();
    check("post rst req", mem_req, 1);
    check("post rst addr", mem_addr, 16'd0);

`ifdef FETCH_STALL_CNT_EN
    do_reset();
    check("stall rst", stall_cycles, 0);
    instr_ready = 1'b1;
    repeat (10) tick();
    check("stall count 10", stall_cycles, 16'd10);
    reset = 1'b0;
    #1;
    check("stall cleared", stall_cycles, 0);
    instr_ready = 1'b0;
    reset = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
